array_stream_writer: RTL and testbench
======================================

Name: array_stream_writer

Overview:
- Write-side companion to the 256x8 eight-read-port lookup array.
- Holds the 256-entry table and exposes eight combinational read ports.
- Replaces the fixed preload with a clocked engine that has two operations:
  - a clear sweep that fills the table with a constant;
  - a streamed burst load (valid/ready) at a base address that wraps around.
- Sits between the host/configuration path and the 1-core datapath readers.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 8, entry width.
- CLEAR_VALUE, 1, value written to every entry by the clear sweep.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst load; sampled in IDLE only.
- base_addr  in  ADDR_W  first address written by the burst; sampled with start.
- length  in  ADDR_W+1  number of beats in the burst (1..DEPTH); sampled with start.
- clear_req  in  1  request for a clear sweep; sampled in IDLE only.
- s_valid  in  1  stream beat valid.
- s_data  in  DATA_W  stream beat data.
- s_ready  out  1  stream beat accept.
- busy  out  1  high in CLEAR or LOAD.
- done  out  1  one-cycle pulse when the last beat of a burst is accepted.
- rd_addr  in  8*ADDR_W  eight packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  8*DATA_W  eight packed read data; rd_data[i] = mem[rd_addr[i]].
- nonzero_count  out  ADDR_W+1  number of nonzero entries (see Optional Feature).

Behaviour:
- States: CLEAR, IDLE, LOAD. Internal registers: ptr (ADDR_W), remaining (ADDR_W+1).
- While reset is high:
  - state = CLEAR, ptr = 0, remaining = 0;
  - s_ready = 0, busy = 1, done = 0, nonzero_count = 0.
  - Memory contents are not reset directly.
- CLEAR:
  - Each cycle writes mem[ptr] <= CLEAR_VALUE, then ptr <= ptr + 1.
  - The cycle that writes ptr == DEPTH-1 moves the FSM to IDLE.
  - The sweep is exactly DEPTH cycles; busy falls on the edge after the 256th write.
  - s_ready = 0; start and clear_req are ignored.
- IDLE: busy = 0, s_ready = 0.
  - clear_req = 1: go to CLEAR, ptr <= 0. clear_req wins if start is high in the same cycle.
  - start = 1 with length == 0: ignored, stay in IDLE.
  - start = 1 with length > 0: go to LOAD, ptr <= base_addr, remaining <= min(length, DEPTH).
- LOAD:
  - s_ready = 1 (registered, high from the first LOAD cycle). busy = 1.
  - A beat is accepted when s_valid && s_ready:
    - mem[ptr] <= s_data;
    - ptr <= ptr + 1, wrapping modulo DEPTH (255 -> 0);
    - remaining <= remaining - 1.
  - The beat accepted with remaining == 1 moves the FSM to IDLE and sets done = 1 for exactly one cycle.
  - s_ready is low in the cycle after the last beat.
  - s_valid low inserts bubbles with no state change.
  - start and clear_req are ignored.
- Reads:
  - Combinational, with no port conflicts.
  - A write becomes visible after the accepting edge; a read in the same cycle returns the old value.
  - Reads are legal in all states; during CLEAR, entries not yet swept return prior contents.
- Reset asserted mid-LOAD or mid-CLEAR:
  - Aborts immediately and drops any beat in flight.
  - After release, the FSM restarts the clear sweep from address 0.

Optional Feature:
- Macro: ARRAY_NONZERO_COUNT_EN.
- Defined: nonzero_count tracks the number of entries that are nonzero.
  - On a LOAD write: count <= count + (s_data != 0) - (old mem[ptr] != 0).
  - On entering CLEAR: count <= 0.
  - During CLEAR: count increments by 1 per write when CLEAR_VALUE != 0.
  - After a completed sweep the count is 256 (CLEAR_VALUE = 1) or 0 (CLEAR_VALUE = 0).
- Not defined: nonzero_count is tied to 0 and no counter logic is generated.

Decomposition:
- Package array_pkg holds:
  - ADDR_W, DATA_W, DEPTH, NUM_RD = 8;
  - the state enum {CLEAR, IDLE, LOAD}.
- Sub-module array_8r1w holds the storage:
  - DEPTH x DATA_W memory;
  - one synchronous write port (we, waddr, wdata);
  - eight combinational read ports.
- The FSM, pointer and counter logic stay in array_stream_writer.

Test Plan:
- Release reset, count cycles, read all 256 addresses:
  - busy falls after exactly 256 clocks;
  - every rd_data = 1;
  - nonzero_count = 256 with the macro defined.
- start, base_addr = 250, length = 10, stream beats 0x10..0x19 with s_valid always high:
  - addresses 250..255 and 0..3 hold 0x10..0x19;
  - done pulses once, on the 10th acceptance;
  - address 4 still reads 1.
- Burst with s_valid toggled every other cycle, length = 4, data 0xAA/0x00/0x55/0x00:
  - exactly 4 writes occur;
  - nonzero_count ends at 254.
- start and clear_req high together in IDLE:
  - the FSM enters CLEAR, not LOAD;
  - after 256 cycles all entries = 1.
- start with length = 0:
  - no state change, busy stays 0, done stays 0.
- Assert reset after 3 beats of a 10-beat burst:
  - s_ready and busy go low/high asynchronously at once, done stays 0;
  - after release, a full clear sweep completes;
  - the 3 written addresses read 1.

Source files
------------

// File: rtl/array_pkg.sv
// Shared constants and types for the 256x8 eight-read-port lookup array and its
// write-side engine (array_stream_writer / array_8r1w).
//
// Contents:
//   ADDR_W  - address width (table depth is 2**ADDR_W)
//   DATA_W  - entry width
//   DEPTH   - number of table entries
//   NUM_RD  - number of combinational read ports
//   state_e - write-engine states
package array_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned NUM_RD = 8;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD
  } state_e;

endpackage

// File: rtl/array_8r1w.sv
// Storage for the lookup table: 2**ADDR_W entries of DATA_W bits, one synchronous
// write port and NUM_RD combinational read ports. No reset on the array itself.
//
// Optional build macro: ARRAY_NONZERO_COUNT_EN adds the wold port, which returns
// the current contents of the entry addressed by waddr (before the write lands).
//
// Ports:
//   clk      in   write clock (rising edge)
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   wold     out  current mem[waddr] (only with ARRAY_NONZERO_COUNT_EN)
//   rd_addr  in   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  out  packed read data, port i at [i*DATA_W +: DATA_W]
module array_8r1w #(
  parameter int unsigned ADDR_W = array_pkg::ADDR_W,
  parameter int unsigned DATA_W = array_pkg::DATA_W,
  parameter int unsigned NUM_RD = array_pkg::NUM_RD
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
`ifdef ARRAY_NONZERO_COUNT_EN
  output logic [DATA_W-1:0]        wold,
`endif
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the old value during the writing cycle; new data after the edge.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
  end

`ifdef ARRAY_NONZERO_COUNT_EN
  assign wold = mem[waddr];
`endif

endmodule

// File: rtl/array_stream_writer.sv
// Write-side engine for the 256x8 eight-read-port lookup array. After reset it
// sweeps the whole table to CLEAR_VALUE, then idles until either a clear sweep or
// a streamed burst load (valid/ready) at a wrapping base address is requested.
//
// Optional build macro: ARRAY_NONZERO_COUNT_EN enables nonzero_count, a running
// count of nonzero table entries. Without it nonzero_count is tied to 0.
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous active-high reset
//   start          in   begin a burst load (sampled in IDLE)
//   base_addr      in   first burst address (sampled with start)
//   length         in   burst beats, 1..DEPTH, larger values clamp (sampled with start)
//   clear_req      in   begin a clear sweep (sampled in IDLE, wins over start)
//   s_valid        in   stream beat valid
//   s_data         in   stream beat data
//   s_ready        out  stream beat accept (high throughout LOAD)
//   busy           out  high in CLEAR or LOAD
//   done           out  one-cycle pulse after the last beat of a burst is taken
//   rd_addr        in   eight packed read addresses
//   rd_data        out  eight packed read data, combinational
//   nonzero_count  out  number of nonzero entries
module array_stream_writer #(
  parameter int unsigned      ADDR_W      = array_pkg::ADDR_W,
  parameter int unsigned      DATA_W      = array_pkg::DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [ADDR_W:0]                      length,
  input  logic                                 clear_req,
  input  logic                                 s_valid,
  input  logic [DATA_W-1:0]                    s_data,
  output logic                                 s_ready,
  output logic                                 busy,
  output logic                                 done,
  input  logic [array_pkg::NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [array_pkg::NUM_RD*DATA_W-1:0]  rd_data,
  output logic [ADDR_W:0]                      nonzero_count
);

  import array_pkg::*;

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned LenW  = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              done_q, done_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

`ifdef ARRAY_NONZERO_COUNT_EN
  logic [DATA_W-1:0] wold;
`endif

  array_8r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_RD (NUM_RD)
  ) u_mem (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
`ifdef ARRAY_NONZERO_COUNT_EN
    .wold    (wold),
`endif
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = ptr_q;
    wdata   = s_data;

    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        wdata = CLEAR_VALUE;
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (start && (length != '0)) begin
          state_d = LOAD;
          ptr_d   = base_addr;
          rem_d   = (length > LenW'(Depth)) ? LenW'(Depth) : length;
        end
      end
      LOAD: begin
        // s_ready is high for the whole of LOAD, so s_valid alone accepts a beat.
        if (s_valid) begin
          we    = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - LenW'(1);
          if (rem_q == LenW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

`ifdef ARRAY_NONZERO_COUNT_EN
  logic [ADDR_W:0] count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case (state_q)
      CLEAR: count_d = count_q + LenW'(CLEAR_VALUE != '0);
      IDLE: begin
        // The sweep rebuilds the count from zero as it rewrites every entry.
        if (clear_req) begin
          count_d = '0;
        end
      end
      LOAD: begin
        if (s_valid) begin
          count_d = count_q + LenW'(s_data != '0) - LenW'(wold != '0);
        end
      end
      default: count_d = '0;
    endcase
  end

  assign nonzero_count = count_q;
`else
  assign nonzero_count = '0;
`endif

endmodule

// File: tb/tb_array_stream_writer.sv
// Bench for array_stream_writer: directed stimulus, a behavioural table model and
// a per-cycle compare process, plus literal expectations at key points.
module tb_array_stream_writer;

  localparam logic [7:0] Clr = 8'd1;
`ifdef ARRAY_NONZERO_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  length = '0;
  logic        clear_req = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        busy;
  logic        done;
  logic [63:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic [8:0]  nonzero_count;

  int n_cmp = 0;
  int n_fail = 0;

  array_stream_writer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .clear_req     (clear_req),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .busy          (busy),
    .done          (done),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .nonzero_count (nonzero_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: table contents plus work still outstanding.
  logic [7:0] mm [256];
  bit         known [256];
  int         sweep_left = 256;
  int         beats_left = 0;
  logic [7:0] load_addr = '0;
  bit         exp_done = 1'b0;
  bit         all_known = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_left <= 256;
      beats_left <= 0;
      exp_done   <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (sweep_left > 0) begin
        mm[8'(256 - sweep_left)]    <= Clr;
        known[8'(256 - sweep_left)] <= 1'b1;
        sweep_left <= sweep_left - 1;
        if (sweep_left == 1) all_known <= 1'b1;
      end else if (beats_left > 0) begin
        if (s_valid) begin
          mm[load_addr]    <= s_data;
          known[load_addr] <= 1'b1;
          load_addr  <= load_addr + 8'd1;
          beats_left <= beats_left - 1;
          if (beats_left == 1) exp_done <= 1'b1;
        end
      end else if (clear_req) begin
        sweep_left <= 256;
      end else if (start && length != 9'd0) begin
        beats_left <= (length > 9'd256) ? 256 : int'(length);
        load_addr  <= base_addr;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int nz;
    logic [7:0] a;
    check("busy", 32'(busy), 32'(sweep_left > 0 || beats_left > 0));
    check("s_ready", 32'(s_ready), 32'(beats_left > 0));
    check("done", 32'(done), 32'(exp_done));
    nz = 0;
    for (int k = 0; k < 256; k++) if (mm[k] != 8'd0) nz++;
    if (reset) check("count_in_reset", 32'(nonzero_count), 32'd0);
    else if (sweep_left == 0 && all_known)
      check("nonzero_count", 32'(nonzero_count), CountEn ? 32'(nz) : 32'd0);
    for (int i = 0; i < 8; i++) begin
      a = rd_addr[i*8 +: 8];
      if (known[a]) check($sformatf("rd_port%0d", i), 32'(rd_data[i*8 +: 8]), 32'(mm[a]));
    end
  end

  logic [7:0] beat_data [16];

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 400) begin
      for (int i = 0; i < 8; i++) rd_addr[i*8 +: 8] = 8'(cyc * 8 + i);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic read_all_ones();
    for (int g = 0; g < 32; g++) begin
      for (int i = 0; i < 8; i++) rd_addr[i*8 +: 8] = 8'(g * 8 + i);
      #1;
      for (int i = 0; i < 8; i++) check("swept_value", 32'(rd_data[i*8 +: 8]), 32'(Clr));
    end
  endtask

  task automatic read_at(input logic [7:0] addr, output logic [7:0] data);
    rd_addr[7:0] = addr;
    #1;
    data = rd_data[7:0];
  endtask

  task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input bit toggle);
    int acc, cyc, dn, dn_at;
    start = 1'b1;
    base_addr = base;
    length = len;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ready_on_load_entry", 32'(s_ready), 32'd1);
    acc = 0;
    cyc = 0;
    dn = 0;
    dn_at = -1;
    while (acc < int'(len) && cyc < 100) begin
      s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data = beat_data[acc];
      @(posedge clk);
      #1;
      if (s_valid) acc++;
      cyc++;
      if (done) begin
        dn++;
        dn_at = acc;
      end
    end
    s_valid = 1'b0;
    check("beats_taken", 32'(acc), 32'(len));
    check("ready_low_after_last", 32'(s_ready), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("done_pulses", 32'(dn), 32'd1);
    check("done_on_last_beat", 32'(dn_at), 32'(len));
    check("idle_after_burst", 32'(busy), 32'd0);
  endtask

  initial begin : timeout
    #300000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int c;
    logic [7:0] d;

    // Reset and the initial sweep.
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_ready", 32'(s_ready), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_count", 32'(nonzero_count), 32'd0);
    reset = 1'b0;
    wait_idle(c);
    check("sweep_cycles", 32'(c), 32'd256);
    read_all_ones();
    check("count_after_sweep", 32'(nonzero_count), CountEn ? 32'd256 : 32'd0);

    // Wrapping burst: 250..255, 0..3 get 0x10..0x19.
    for (int k = 0; k < 10; k++) beat_data[k] = 8'(8'h10 + k);
    run_burst(8'd250, 9'd10, 1'b0);
    read_at(8'd250, d); check("wrap_250", 32'(d), 32'h10);
    read_at(8'd255, d); check("wrap_255", 32'(d), 32'h15);
    read_at(8'd0, d);   check("wrap_0", 32'(d), 32'h16);
    read_at(8'd3, d);   check("wrap_3", 32'(d), 32'h19);
    read_at(8'd4, d);   check("wrap_4_untouched", 32'(d), 32'h01);
    read_at(8'd249, d); check("wrap_249_untouched", 32'(d), 32'h01);

    // Bubbled burst with two zero beats.
    beat_data[0] = 8'hAA;
    beat_data[1] = 8'h00;
    beat_data[2] = 8'h55;
    beat_data[3] = 8'h00;
    run_burst(8'd100, 9'd4, 1'b1);
    read_at(8'd100, d); check("bub_100", 32'(d), 32'hAA);
    read_at(8'd101, d); check("bub_101", 32'(d), 32'h00);
    read_at(8'd102, d); check("bub_102", 32'(d), 32'h55);
    read_at(8'd103, d); check("bub_103", 32'(d), 32'h00);
    read_at(8'd104, d); check("bub_104_untouched", 32'(d), 32'h01);
    check("count_after_bubbles", 32'(nonzero_count), CountEn ? 32'd254 : 32'd0);

    // clear_req beats start.
    start = 1'b1;
    clear_req = 1'b1;
    base_addr = 8'd0;
    length = 9'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    clear_req = 1'b0;
    check("clear_wins_busy", 32'(busy), 32'd1);
    check("clear_wins_no_ready", 32'(s_ready), 32'd0);
    wait_idle(c);
    check("clear_sweep_cycles", 32'(c), 32'd256);
    read_all_ones();

    // Zero-length start is ignored.
    start = 1'b1;
    length = 9'd0;
    base_addr = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("len0_still_idle", 32'(busy), 32'd0);

    // Reset after 3 beats of a 10-beat burst.
    start = 1'b1;
    base_addr = 8'd20;
    length = 9'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data = 8'(8'h30 + k);
      @(posedge clk);
      #1;
    end
    read_at(8'd22, d); check("pre_reset_22", 32'(d), 32'h32);
    reset = 1'b1;
    #1;
    check("async_ready_low", 32'(s_ready), 32'd0);
    check("async_busy_high", 32'(busy), 32'd1);
    check("async_done_low", 32'(done), 32'd0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_idle(c);
    check("resweep_cycles", 32'(c), 32'd256);
    read_at(8'd20, d); check("resweep_20", 32'(d), 32'h01);
    read_at(8'd21, d); check("resweep_21", 32'(d), 32'h01);
    read_at(8'd22, d); check("resweep_22", 32'(d), 32'h01);
    check("count_after_resweep", 32'(nonzero_count), CountEn ? 32'd256 : 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
